// File: rtl/branch_ctrl_pkg.sv
// Shared MIPS decode constants, branch-controller state and decode types.
// Decode and hazard helpers are reused by the ID-stage branch logic.
package cpu_defines;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;

   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;

   localparam logic [4:0] RT_BLTZ    = 5'b00000;
   localparam logic [4:0] RT_BGEZ    = 5'b00001;
   localparam logic [4:0] RT_BLTZAL  = 5'b10000;
   localparam logic [4:0] RT_BGEZAL  = 5'b10001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESOLVE = 2'd2
   } br_state_t;

   typedef struct packed {
      logic is_br;
      logic use_rs;
      logic use_rt;
      logic is_j;
      logic is_jr;
      logic link;
   } br_dec_t;

   function automatic br_dec_t br_decode(input logic [5:0] op,
                                         input logic [5:0] funct,
                                         input logic [4:0] rt);
      br_dec_t d;
      d = '0;
      case (op)
         OP_BEQ, OP_BNE: begin
            d.is_br  = 1'b1;
            d.use_rs = 1'b1;
            d.use_rt = 1'b1;
         end
         OP_BLEZ, OP_BGTZ: begin
            d.is_br  = 1'b1;
            d.use_rs = 1'b1;
         end
         OP_REGIMM: begin
            if (rt == RT_BLTZ || rt == RT_BGEZ) begin
               d.is_br  = 1'b1;
               d.use_rs = 1'b1;
            end else if (rt == RT_BLTZAL || rt == RT_BGEZAL) begin
               d.is_br  = 1'b1;
               d.use_rs = 1'b1;
               d.link   = 1'b1;
            end
         end
         OP_J: begin
            d.is_br = 1'b1;
            d.is_j  = 1'b1;
         end
         OP_JAL: begin
            d.is_br = 1'b1;
            d.is_j  = 1'b1;
            d.link  = 1'b1;
         end
         OP_SPECIAL: begin
            if (funct == FN_JR || funct == FN_JALR) begin
               d.is_br  = 1'b1;
               d.use_rs = 1'b1;
               d.is_jr  = 1'b1;
               d.link   = (funct == FN_JALR);
            end
         end
         default: ;
      endcase
      return d;
   endfunction

   // Cycles ID must wait before source r is available via MEM forward or RF.
   function automatic logic [1:0] hz_count(input logic [4:0] r,
                                           input logic       ex_regwrite,
                                           input logic       ex_memtoreg,
                                           input logic [4:0] ex_wreg,
                                           input logic       mem_regwrite,
                                           input logic       mem_memtoreg,
                                           input logic [4:0] mem_wreg);
      if (r == 5'd0)
         return 2'd0;
      if (ex_regwrite && ex_wreg == r)
         return ex_memtoreg ? 2'd2 : 2'd1;
      if (mem_regwrite && mem_memtoreg && mem_wreg == r)
         return 2'd1;
      return 2'd0;
   endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// ID-stage bundle between the decode pipeline and the branch controller.
interface branch_ctrl_if;
   import cpu_defines::*;

   logic        id_valid;
   logic [5:0]  id_op;
   logic [5:0]  id_funct;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [15:0] id_imm;
   logic [25:0] id_index;
   logic [31:0] id_pc_plus4;
   logic [31:0] rf_rs_data;
   logic [31:0] rf_rt_data;
   logic        ex_regwrite;
   logic        ex_memtoreg;
   logic [4:0]  ex_wreg;
   logic        mem_regwrite;
   logic        mem_memtoreg;
   logic [4:0]  mem_wreg;
   logic [31:0] mem_alu_result;
   logic        flush;
   logic        stall_id;
   logic        redirect;
   logic [31:0] branch_target;
   logic        link_en;
   logic        in_delay_slot;

   modport master (
      output id_valid, id_op, id_funct, id_rs, id_rt, id_imm, id_index,
             id_pc_plus4, rf_rs_data, rf_rt_data, ex_regwrite, ex_memtoreg,
             ex_wreg, mem_regwrite, mem_memtoreg, mem_wreg, mem_alu_result,
             flush,
      input  stall_id, redirect, branch_target, link_en, in_delay_slot
   );

   modport slave (
      input  id_valid, id_op, id_funct, id_rs, id_rt, id_imm, id_index,
             id_pc_plus4, rf_rs_data, rf_rt_data, ex_regwrite, ex_memtoreg,
             ex_wreg, mem_regwrite, mem_memtoreg, mem_wreg, mem_alu_result,
             flush,
      output stall_id, redirect, branch_target, link_en, in_delay_slot
   );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition from opcode, REGIMM rt and the two operands.
module branch_cond
   import cpu_defines::*;
(
   input  logic [5:0]  op,
   input  logic [4:0]  rt,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        cond
);

   always_comb begin
      cond = 1'b0;
      case (op)
         OP_BEQ:  cond = (a == b);
         OP_BNE:  cond = (a != b);
         OP_BGTZ: cond = ~a[31] & (a != 32'd0);
         OP_BLEZ: cond = a[31] | (a == 32'd0);
         OP_REGIMM: begin
            case (rt)
               RT_BGEZ, RT_BGEZAL: cond = ~a[31];
               RT_BLTZ, RT_BLTZAL: cond = a[31];
               default:            cond = 1'b0;
            endcase
         end
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// Decode-stage branch/jump controller: hazard stall, operand forward,
// condition evaluation, redirect/link generation and delay-slot tracking.
module branch_ctrl
   import cpu_defines::*;
(
   input  logic         clk,
   input  logic         rst,
   branch_ctrl_if.slave bus
);

   br_state_t   state, state_nx;
   logic [1:0]  cnt, cnt_nx;
   logic        ds_flag;
   br_dec_t     dec;
   logic        br, eval, stall, cond;
   logic [1:0]  n_rs, n_rt, n;
   logic [31:0] a, b, target;

   assign dec  = br_decode(bus.id_op, bus.id_funct, bus.id_rt);
   assign br   = bus.id_valid & dec.is_br;

   assign n_rs = dec.use_rs ? hz_count(bus.id_rs, bus.ex_regwrite, bus.ex_memtoreg,
                                       bus.ex_wreg, bus.mem_regwrite,
                                       bus.mem_memtoreg, bus.mem_wreg) : 2'd0;
   assign n_rt = dec.use_rt ? hz_count(bus.id_rt, bus.ex_regwrite, bus.ex_memtoreg,
                                       bus.ex_wreg, bus.mem_regwrite,
                                       bus.mem_memtoreg, bus.mem_wreg) : 2'd0;
   assign n    = (n_rs > n_rt) ? n_rs : n_rt;

   assign a = (bus.mem_regwrite && !bus.mem_memtoreg && bus.mem_wreg == bus.id_rs &&
               bus.id_rs != 5'd0) ? bus.mem_alu_result : bus.rf_rs_data;
   assign b = (bus.mem_regwrite && !bus.mem_memtoreg && bus.mem_wreg == bus.id_rt &&
               bus.id_rt != 5'd0) ? bus.mem_alu_result : bus.rf_rt_data;

   branch_cond u_cond (
      .op   (bus.id_op),
      .rt   (bus.id_rt),
      .a    (a),
      .b    (b),
      .cond (cond)
   );

   always_comb begin
      if (dec.is_j)
         target = {bus.id_pc_plus4[31:28], bus.id_index, 2'b00};
      else if (dec.is_jr)
         target = a;
      else
         target = bus.id_pc_plus4 + {{14{bus.id_imm[15]}}, bus.id_imm, 2'b00};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= 2'd0;
         ds_flag <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (bus.flush)
            ds_flag <= 1'b0;
         else if (eval)
            ds_flag <= 1'b1;
         else if (bus.id_valid && !stall)
            ds_flag <= 1'b0;
      end
   end

   // The detect cycle is itself the first stall, so a one-cycle hazard
   // goes straight to RESOLVE and only a load-use hazard passes through WAIT.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      eval     = 1'b0;
      stall    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (br) begin
               if (n == 2'd0) begin
                  eval = 1'b1;
               end else begin
                  stall    = 1'b1;
                  cnt_nx   = n - 2'd1;
                  state_nx = (n == 2'd1) ? ST_RESOLVE : ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            stall = 1'b1;
            if (cnt <= 2'd1) begin
               cnt_nx   = 2'd0;
               state_nx = ST_RESOLVE;
            end else begin
               cnt_nx = cnt - 2'd1;
            end
         end
         ST_RESOLVE: begin
            eval     = dec.is_br;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (rst || bus.flush) begin
         state_nx = ST_IDLE;
         cnt_nx   = 2'd0;
         eval     = 1'b0;
         stall    = 1'b0;
      end
   end

   assign bus.stall_id      = stall;
   assign bus.redirect      = eval & (dec.is_j | dec.is_jr | cond);
   assign bus.link_en       = eval & dec.link;
   assign bus.branch_target = eval ? target : 32'd0;
   assign bus.in_delay_slot = ds_flag & bus.id_valid & ~rst;

endmodule
